// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver: filters ps2c, deframes 11-bit frames, folds E0/F0 prefixes
// into ext/brk flags and queues key events in a small FIFO read through a status/data port.
module ps2_keyboard_fifo #(
   parameter int FIFO_DEPTH     = 8,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2d,
   input  logic        ps2c,
   input  logic        ack,
   output logic [15:0] dout
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, CHECK = 2'd2} state_t;

   state_t                  state;
   state_t                  state_nx;
   logic [1:0]              c_sync;
   logic [1:0]              d_sync;
   logic [FILTER_LEN-1:0]   filter;
   logic                    filt_clk;
   logic                    fall_edge;
   logic [9:0]              shreg;
   logic [3:0]              bit_cnt;
   logic [TW-1:0]           tmo_cnt;
   logic                    ext;
   logic                    brk;
   logic                    err;
   logic                    ovf;
   logic                    ack_q;
   logic [9:0]              mem [FIFO_DEPTH];
   logic [PW-1:0]           rd_ptr;
   logic [PW-1:0]           wr_ptr;
   logic [CW-1:0]           count;
   logic                    frame_ok;
   logic                    frame_err;
   logic                    push;
   logic                    pop;
   logic                    ack_rise;
   logic                    full;
   logic                    do_write;
   logic [7:0]              code;

   // Two-flop synchronisers followed by the ps2c glitch filter.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_sync    <= 2'b11;
         d_sync    <= 2'b11;
         filter    <= '1;
         filt_clk  <= 1'b1;
         fall_edge <= 1'b0;
      end else begin
         c_sync    <= {c_sync[0], ps2c};
         d_sync    <= {d_sync[0], ps2d};
         filter    <= {filter[FILTER_LEN-2:0], c_sync[1]};
         fall_edge <= filt_clk & ~(|filter);
         if (&filter)
            filt_clk <= 1'b1;
         else if (~(|filter))
            filt_clk <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (fall_edge && !d_sync[1]) state_nx = DATA;
         DATA: begin
            if (fall_edge && bit_cnt == 4'd9)
               state_nx = CHECK;
            else if (!fall_edge && tmo_cnt == TW'(TIMEOUT_CYCLES - 1))
               state_nx = IDLE;
         end
         CHECK:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // shreg holds {stop, parity, data[7:0]} once ten bits have been shifted in.
   assign code = shreg[7:0];

   always_comb begin
      frame_ok  = 1'b0;
      frame_err = 1'b0;
      push      = 1'b0;
      if (state == CHECK) begin
         frame_ok  = (^shreg[8:0]) & shreg[9];
         frame_err = ~frame_ok;
         push      = frame_ok && code != 8'hE0 && code != 8'hF0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '0;
         bit_cnt <= '0;
         tmo_cnt <= '0;
      end else if (state == DATA) begin
         if (fall_edge) begin
            shreg   <= {d_sync[1], shreg[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end else begin
         bit_cnt <= '0;
         tmo_cnt <= '0;
      end
   end

   assign ack_rise = ack & ~ack_q;
   assign full     = (count == CW'(FIFO_DEPTH));
   assign pop      = ack_rise & (count != '0);
   assign do_write = push & (~full | pop);

   // A new error or overflow in the same cycle as an ack edge stays visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q <= 1'b0;
         ext   <= 1'b0;
         brk   <= 1'b0;
         err   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         ack_q <= ack;
         if (frame_err)
            err <= 1'b1;
         else if (ack_rise)
            err <= 1'b0;
         if (push && full && !pop)
            ovf <= 1'b1;
         else if (ack_rise)
            ovf <= 1'b0;
         if (frame_err || push) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (frame_ok) begin
            if (code == 8'hE0) ext <= 1'b1;
            if (code == 8'hF0) brk <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + 1'b1;
         if (pop)      rd_ptr <= rd_ptr + 1'b1;
         if (do_write && !pop)
            count <= count + 1'b1;
         else if (!do_write && pop)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_write)
         mem[wr_ptr] <= {ext, brk, code};
   end

   always_comb begin
      dout = 16'h0000;
      if (ack) begin
         if (count != '0)
            dout = {6'b0, mem[rd_ptr]};
      end else begin
         dout = {8'h00, 4'(count), err, ovf, full, (count != '0)};
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Directed bench for ps2_keyboard_fifo: drives PS/2 frames bit by bit and checks
// status and event words with immediate assertions.
module tb_ps2_keyboard_fifo;

   localparam int HALF = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        ps2d;
   logic        ps2c;
   logic        ack;
   logic [15:0] dout;
   int          checks = 0;
   int          errors = 0;

   ps2_keyboard_fifo #(
      .FIFO_DEPTH    (4),
      .FILTER_LEN    (4),
      .TIMEOUT_CYCLES(200)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ps2d(ps2d),
      .ps2c(ps2c),
      .ack (ack),
      .dout(dout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk) ps2d = b;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) ps2_bit(bits[i]);
   endtask

   task automatic send_frame(input logic [7:0] code, input logic bad_par);
      logic [10:0] bits;
      bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
      send_bits(bits, 11);
      ps2d = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic check_status(input string tag, input logic [15:0] exp);
      @(negedge clk);
      #1 chk(tag, dout, exp);
   endtask

   task automatic ack_read(input string tag, input logic [15:0] exp);
      @(negedge clk) ack = 1'b1;
      #1 chk(tag, dout, exp);
      repeat (3) @(negedge clk);
      ack = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      ps2d = 1'b1;
      ps2c = 1'b1;
      ack  = 1'b0;
      do_reset();
      check_status("reset_status", 16'h0000);
      ack_read("reset_empty_data", 16'h0000);

      // Plain key
      send_frame(8'h1C, 1'b0);
      check_status("plain_status", 16'h0011);
      ack_read("plain_data", 16'h001C);
      check_status("plain_after", 16'h0000);

      // Extended break sequence
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      check_status("extbrk_status", 16'h0011);
      ack_read("extbrk_data", 16'h0375);
      send_frame(8'h1C, 1'b0);
      ack_read("prefix_cleared", 16'h001C);
      check_status("extbrk_after", 16'h0000);

      // Parity error
      send_frame(8'h1C, 1'b1);
      check_status("parity_err_status", 16'h0008);
      ack_read("parity_err_empty", 16'h0000);
      check_status("parity_err_cleared", 16'h0000);

      // Overflow on a depth-4 FIFO
      send_frame(8'h16, 1'b0);
      send_frame(8'h1E, 1'b0);
      send_frame(8'h26, 1'b0);
      check_status("three_queued", 16'h0031);
      send_frame(8'h25, 1'b0);
      check_status("full_status", 16'h0043);
      send_frame(8'h2E, 1'b0);
      check_status("ovf_status", 16'h0047);
      ack_read("ovf_read0", 16'h0016);
      check_status("ovf_cleared", 16'h0031);
      ack_read("ovf_read1", 16'h001E);
      ack_read("ovf_read2", 16'h0026);
      ack_read("ovf_read3", 16'h0025);
      check_status("ovf_drained", 16'h0000);

      // Partial frame timeout
      send_bits(11'b000_0000_1000, 4);
      repeat (400) @(negedge clk);
      check_status("timeout_no_err", 16'h0000);
      send_frame(8'h1C, 1'b0);
      check_status("timeout_recover", 16'h0011);
      ack_read("timeout_data", 16'h001C);

      // Reset mid-frame
      send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
      do_reset();
      check_status("midreset_status", 16'h0000);
      send_frame(8'h29, 1'b0);
      check_status("midreset_recover", 16'h0011);
      ack_read("midreset_data", 16'h0029);
      check_status("final_empty", 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
